// File: rtl/led_trail_fader.sv
// Shooting-trail LED fader: strikes load PEAK, a global decay timer fades each LED, shared PWM renders cats.
// Optional LED_TRAIL_GAMMA_EN squares brightness through one extra register for a perceptually linear fade.
module led_trail_fader #(
    parameter int unsigned CLK_FREQ    = 48_000_000,
    parameter int unsigned PWM_DIV     = 1,
    parameter int unsigned DECAY_TICKS = CLK_FREQ / 64,
    parameter logic [7:0]  DECAY_STEP  = 8'd8,
    parameter logic [7:0]  PEAK        = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pattern,
    input  logic       pattern_valid,
    input  logic       freeze,
    output logic [7:0] cats,
    output logic       idle
);

    logic [31:0]      pwm_div_cnt_q, pwm_div_cnt_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [31:0]      decay_cnt_q, decay_cnt_d;
    logic [7:0][7:0]  bright_q, bright_d;
    logic [7:0][7:0]  lvl;
    logic [7:0]       cats_q, cats_d;
    logic             idle_q, idle_d;
    logic             pwm_wrap;
    logic             tick;

    // Timers: PWM prescaler, 255-step PWM counter, and the global decay tick.
    always_comb begin
        pwm_wrap      = (pwm_div_cnt_q == PWM_DIV - 32'd1);
        pwm_div_cnt_d = pwm_wrap ? 32'd0 : pwm_div_cnt_q + 32'd1;
        pwm_cnt_d     = pwm_cnt_q;
        if (pwm_wrap) begin
            pwm_cnt_d = (pwm_cnt_q == 8'd254) ? 8'd0 : pwm_cnt_q + 8'd1;
        end
        tick        = (decay_cnt_q == DECAY_TICKS - 32'd1);
        decay_cnt_d = tick ? 32'd0 : decay_cnt_q + 32'd1;
    end

    // Strike beats decay and freeze; decay saturates at zero.
    always_comb begin
        bright_d = bright_q;
        for (int i = 0; i < 8; i++) begin
            if (pattern_valid && pattern[i]) begin
                bright_d[i] = PEAK;
            end else if (tick && !freeze) begin
                bright_d[i] = (bright_q[i] > DECAY_STEP) ? bright_q[i] - DECAY_STEP : 8'd0;
            end
        end
        idle_d = (bright_d == '0);
    end

`ifdef LED_TRAIL_GAMMA_EN
    logic [7:0][7:0] lvl_q, lvl_d;
    logic [15:0]     sq;

    always_comb begin
        lvl_d = '0;
        sq    = 16'd0;
        for (int i = 0; i < 8; i++) begin
            sq       = {8'd0, bright_q[i]} * {8'd0, bright_q[i]};
            lvl_d[i] = (bright_q[i] == 8'd255) ? 8'd255 : sq[15:8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q <= '0;
        end else begin
            lvl_q <= lvl_d;
        end
    end

    assign lvl = lvl_q;
`else
    assign lvl = bright_q;
`endif

    // Level 255 exceeds every pwm_cnt value (max 254), so full brightness is solid on.
    always_comb begin
        cats_d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            cats_d[i] = (lvl[i] > pwm_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_div_cnt_q <= 32'd0;
            pwm_cnt_q     <= 8'd0;
            decay_cnt_q   <= 32'd0;
            bright_q      <= '0;
            cats_q        <= 8'h00;
            idle_q        <= 1'b1;
        end else begin
            pwm_div_cnt_q <= pwm_div_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            decay_cnt_q   <= decay_cnt_d;
            bright_q      <= bright_d;
            cats_q        <= cats_d;
            idle_q        <= idle_d;
        end
    end

    assign cats = cats_q;
    assign idle = idle_q;

endmodule

// File: tb/tb_led_trail_fader.sv
// Directed bench for led_trail_fader: two instances (step 64 and step 8) driven by shared stimulus.
// Brightness is observed as PWM duty: with freeze held, high cycles over 255 cycles equal the level.
module tb_led_trail_fader;

    logic       clk;
    logic       rst;
    logic [7:0] pattern;
    logic       pattern_valid;
    logic       freeze;
    logic [7:0] cats_a, cats_b;
    logic       idle_a, idle_b;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc;
    int cnt_a [8];
    int cnt_b [8];

    led_trail_fader #(
        .PWM_DIV(1), .DECAY_TICKS(16), .DECAY_STEP(8'd64), .PEAK(8'd255)
    ) dut_a (
        .clk(clk), .rst(rst), .pattern(pattern), .pattern_valid(pattern_valid),
        .freeze(freeze), .cats(cats_a), .idle(idle_a)
    );

    led_trail_fader #(
        .PWM_DIV(1), .DECAY_TICKS(16), .DECAY_STEP(8'd8), .PEAK(8'd255)
    ) dut_b (
        .clk(clk), .rst(rst), .pattern(pattern), .pattern_valid(pattern_valid),
        .freeze(freeze), .cats(cats_b), .idle(idle_b)
    );

    // Clock and reset-relative edge counter; decay edges are those where cyc becomes a multiple of 16.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Stop at the negedge whose following posedge is a decay tick.
    task automatic tick_align();
        for (int n = 0; n < 40 && (cyc % 16) != 15; n++) @(negedge clk);
        if ((cyc % 16) != 15) check("tick_align_timeout", cyc % 16, 15);
    endtask

    task automatic strobe(input logic [7:0] pat);
        pattern       = pat;
        pattern_valid = 1'b1;
        @(negedge clk);
        pattern_valid = 1'b0;
        pattern       = 8'h00;
    endtask

    // Let exactly one decay tick through, freeze again afterwards.
    task automatic one_tick();
        tick_align();
        freeze = 1'b0;
        @(negedge clk);
        freeze = 1'b1;
    endtask

    task automatic measure();
        for (int b = 0; b < 8; b++) begin
            cnt_a[b] = 0;
            cnt_b[b] = 0;
        end
        @(negedge clk);
        for (int i = 0; i < 255; i++) begin
            for (int b = 0; b < 8; b++) begin
                cnt_a[b] += int'(cats_a[b]);
                cnt_b[b] += int'(cats_b[b]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst           = 1'b1;
        pattern       = 8'h00;
        pattern_valid = 1'b0;
        freeze        = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_cats", int'(cats_a), 0);
        check("reset_idle", int'(idle_a), 1);
        rst = 1'b0;

        // Strike 0x81 on a tick edge: strike wins, full-on until the next tick.
        tick_align();
        strobe(8'h81);
        check("strike_idle_drops", int'(idle_a), 0);
        check("strike_cats_latency", int'(cats_a), 0);
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            check("strike_cats_on", int'(cats_a), 8'h81);
        end
        freeze = 1'b1;
        measure();
        check("peak_bit0", cnt_a[0], 255);
        check("peak_bit7", cnt_a[7], 255);
        check("peak_bit1_off", cnt_a[1], 0);

        // Linear decay with step 64.
        one_tick();
        measure();
        check("decay1_a", cnt_a[0], 191);
        check("decay1_b", cnt_b[0], 247);
        one_tick();
        measure();
        check("duty127_bit0", cnt_a[0], 127);
        check("duty127_bit7", cnt_a[7], 127);
        one_tick();
        check("idle_before_last", int'(idle_a), 0);
        measure();
        check("decay3_a", cnt_a[0], 63);
        one_tick();
        check("idle_after_4th", int'(idle_a), 1);
        measure();
        check("decay4_a_zero", cnt_a[0], 0);
        check("decay4_b", cnt_b[0], 223);

        // Strike while frozen, then hold across five tick periods.
        strobe(8'h02);
        check("frozen_strike_idle", int'(idle_a), 0);
        repeat (80) @(negedge clk);
        measure();
        check("freeze_a_bit1", cnt_a[1], 255);
        check("freeze_b_bit0", cnt_b[0], 223);
        check("freeze_b_bit1", cnt_b[1], 255);

        // Nineteen ticks, then strike bit0 on a tick edge.
        for (int t = 0; t < 19; t++) one_tick();
        tick_align();
        freeze = 1'b0;
        strobe(8'h01);
        freeze = 1'b1;
        measure();
        check("collide_b_bit0", cnt_b[0], 255);
        check("collide_b_bit1", cnt_b[1], 95);
        check("collide_a_bit0", cnt_a[0], 255);
        check("saturate_a_bit1", cnt_a[1], 0);

        // Asynchronous reset mid-fade.
        #2 rst = 1'b1;
        #1;
        check("async_rst_cats", int'({cats_a, cats_b}), 0);
        check("async_rst_idle", int'({idle_a, idle_b}), 3);
        for (int k = 0; k < 10; k++) begin
            repeat (100) @(negedge clk);
            check("rst_hold_cats", int'({cats_a, cats_b}), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", int'({idle_a, idle_b}), 3);
        measure();
        check("post_rst_dark_a", cnt_a[0] + cnt_a[1] + cnt_a[7], 0);
        check("post_rst_dark_b", cnt_b[0] + cnt_b[1] + cnt_b[7], 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
